// File: rtl/ivs_axi_sram_slave.sv
// AXI responder backed by a 16-byte-wide register-array memory; independent read and write paths.
// Optional B channel: define IVS_AXI_BRESP_EN to add bvalid/bid/bresp/bready and the W_RESP state.
module ivs_axi_sram_slave #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic         i_aclk,
    input  logic         i_arst,
    input  logic         i_arvalid,
    output logic         o_arready,
    input  logic [3:0]   i_arid,
    input  logic [5:0]   i_arlen,
    input  logic [31:0]  i_araddr,
    input  logic [1:0]   i_arburst,
    output logic         o_rvalid,
    input  logic         i_rready,
    output logic [3:0]   o_rid,
    output logic [127:0] o_rdata,
    output logic         o_rlast,
    output logic [1:0]   o_rresp,
    input  logic         i_awvalid,
    output logic         o_awready,
    input  logic [3:0]   i_awid,
    input  logic [5:0]   i_awlen,
    input  logic [31:0]  i_awaddr,
    input  logic [1:0]   i_awburst,
    input  logic         i_wvalid,
    output logic         o_wready,
    input  logic [3:0]   i_wid,
    input  logic [127:0] i_wdata,
    input  logic [15:0]  i_wstrb,
    input  logic         i_wlast,
`ifdef IVS_AXI_BRESP_EN
    output logic         o_bvalid,
    output logic [3:0]   o_bid,
    output logic [1:0]   o_bresp,
    input  logic         i_bready,
`endif
    output logic         o_proto_err
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned AXI_AW = 32;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned CNT_W  = LEN_W + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Read path registers
    rstate_t           r_rstate, w_rstate_nxt;
    logic [AXI_AW-1:0] r_raddr, w_raddr_nxt;
    logic [LEN_W-1:0]  r_rremain, w_rremain_nxt;
    logic [1:0]        r_rburst, w_rburst_nxt;
    logic              r_arready, w_arready_nxt;
    logic              r_rvalid, w_rvalid_nxt;
    logic [ID_W-1:0]   r_rid, w_rid_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_rlast, w_rlast_nxt;
    logic [1:0]        r_rresp, w_rresp_nxt;

    // Write path registers
    wstate_t           r_wstate, w_wstate_nxt;
    logic [AXI_AW-1:0] r_waddr, w_waddr_nxt;
    logic [LEN_W-1:0]  r_wlen, w_wlen_nxt;
    logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt;
    logic [1:0]        r_wburst, w_wburst_nxt;
    logic [ID_W-1:0]   r_wid, w_wid_nxt;
    logic              r_awready, w_awready_nxt;
    logic              r_wready, w_wready_nxt;
    logic              r_proto_err, w_proto_nxt;
`ifdef IVS_AXI_BRESP_EN
    logic              r_wslverr, w_wslverr_nxt;
    logic              r_bvalid, w_bvalid_nxt;
    logic [ID_W-1:0]   r_bid, w_bid_nxt;
    logic [1:0]        r_bresp, w_bresp_nxt;
`endif

    logic [AXI_AW-1:0] w_raddr_step;
    logic [AXI_AW-1:0] w_rd_addr;
    logic              w_rd_oor;
    logic [DATA_W-1:0] w_rd_data;
    logic [AXI_AW-1:0] w_waddr_step;
    logic              w_wr_oor;
    logic              w_wlast_slot;
    logic              w_mem_we;

    // Fetch address: AR address on accept, otherwise the next beat of the active burst
    assign w_raddr_step = (r_rburst == BURST_FIXED) ? r_raddr : r_raddr + AXI_AW'(16);
    assign w_rd_addr    = (r_rstate == R_IDLE) ? i_araddr : w_raddr_step;
    assign w_rd_oor     = (w_rd_addr[AXI_AW-1:ADDR_W+4] != '0);
    assign w_rd_data    = w_rd_oor ? '0 : r_mem[w_rd_addr[ADDR_W+3:4]];

    assign w_waddr_step = (r_wburst == BURST_FIXED) ? r_waddr : r_waddr + AXI_AW'(16);
    assign w_wr_oor     = (r_waddr[AXI_AW-1:ADDR_W+4] != '0);
    assign w_wlast_slot = (r_wcnt == {1'b0, r_wlen});

    // Read FSM next state and outputs
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_raddr_nxt   = r_raddr;
        w_rremain_nxt = r_rremain;
        w_rburst_nxt  = r_rburst;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rid_nxt     = r_rid;
        w_rdata_nxt   = r_rdata;
        w_rlast_nxt   = r_rlast;
        w_rresp_nxt   = r_rresp;
        case (r_rstate)
            R_IDLE: begin
                w_arready_nxt = 1'b1;
                if (i_arvalid && r_arready) begin
                    w_rstate_nxt  = R_DATA;
                    w_arready_nxt = 1'b0;
                    w_raddr_nxt   = i_araddr;
                    w_rremain_nxt = i_arlen;
                    w_rburst_nxt  = i_arburst;
                    w_rid_nxt     = i_arid;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_rd_data;
                    w_rresp_nxt   = w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                    w_rlast_nxt   = (i_arlen == '0);
                end
            end
            R_DATA: begin
                if (r_rvalid && i_rready) begin
                    if (r_rlast) begin
                        w_rstate_nxt  = R_IDLE;
                        w_arready_nxt = 1'b1;
                        w_rvalid_nxt  = 1'b0;
                        w_rlast_nxt   = 1'b0;
                        w_rdata_nxt   = '0;
                        w_rresp_nxt   = RESP_OKAY;
                    end else begin
                        w_raddr_nxt   = w_raddr_step;
                        w_rremain_nxt = r_rremain - LEN_W'(1);
                        w_rdata_nxt   = w_rd_data;
                        w_rresp_nxt   = w_rd_oor ? RESP_SLVERR : RESP_OKAY;
                        w_rlast_nxt   = (r_rremain == LEN_W'(1));
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Write FSM next state, outputs and memory write enable
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_waddr_nxt   = r_waddr;
        w_wlen_nxt    = r_wlen;
        w_wcnt_nxt    = r_wcnt;
        w_wburst_nxt  = r_wburst;
        w_wid_nxt     = r_wid;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_proto_nxt   = r_proto_err;
        w_mem_we      = 1'b0;
`ifdef IVS_AXI_BRESP_EN
        w_wslverr_nxt = r_wslverr;
        w_bvalid_nxt  = r_bvalid;
        w_bid_nxt     = r_bid;
        w_bresp_nxt   = r_bresp;
`endif
        case (r_wstate)
            W_IDLE: begin
                w_awready_nxt = 1'b1;
                w_wready_nxt  = 1'b0;
                if (i_awvalid && r_awready) begin
                    w_wstate_nxt  = W_DATA;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_waddr_nxt   = i_awaddr;
                    w_wlen_nxt    = i_awlen;
                    w_wcnt_nxt    = '0;
                    w_wburst_nxt  = i_awburst;
                    w_wid_nxt     = i_awid;
`ifdef IVS_AXI_BRESP_EN
                    w_wslverr_nxt = 1'b0;
`endif
                end
            end
            W_DATA: begin
                if (i_wvalid && r_wready) begin
                    w_mem_we = !w_wr_oor;
                    if ((i_wlast != w_wlast_slot) || (i_wid != r_wid))
                        w_proto_nxt = 1'b1;
`ifdef IVS_AXI_BRESP_EN
                    w_wslverr_nxt = r_wslverr | w_wr_oor;
`endif
                    if (i_wlast) begin
                        w_wready_nxt = 1'b0;
`ifdef IVS_AXI_BRESP_EN
                        w_wstate_nxt = W_RESP;
                        w_bvalid_nxt = 1'b1;
                        w_bid_nxt    = r_wid;
                        w_bresp_nxt  = (r_wslverr | w_wr_oor) ? RESP_SLVERR : RESP_OKAY;
`else
                        w_wstate_nxt  = W_IDLE;
                        w_awready_nxt = 1'b1;
`endif
                    end else begin
                        w_waddr_nxt = w_waddr_step;
                        // Saturate so an overlong burst never re-matches the awlen slot
                        w_wcnt_nxt  = (r_wcnt == '1) ? r_wcnt : r_wcnt + CNT_W'(1);
                    end
                end
            end
            W_RESP: begin
`ifdef IVS_AXI_BRESP_EN
                if (i_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_wstate_nxt  = W_IDLE;
                    w_awready_nxt = 1'b1;
                end
`else
                w_wstate_nxt = W_IDLE;
`endif
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge i_aclk) begin
        if (i_arst) begin
            r_rstate    <= R_IDLE;
            r_raddr     <= '0;
            r_rremain   <= '0;
            r_rburst    <= '0;
            r_arready   <= 1'b1;
            r_rvalid    <= 1'b0;
            r_rid       <= '0;
            r_rdata     <= '0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_wstate    <= W_IDLE;
            r_waddr     <= '0;
            r_wlen      <= '0;
            r_wcnt      <= '0;
            r_wburst    <= '0;
            r_wid       <= '0;
            r_awready   <= 1'b1;
            r_wready    <= 1'b0;
            r_proto_err <= 1'b0;
`ifdef IVS_AXI_BRESP_EN
            r_wslverr   <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= RESP_OKAY;
`endif
        end else begin
            r_rstate    <= w_rstate_nxt;
            r_raddr     <= w_raddr_nxt;
            r_rremain   <= w_rremain_nxt;
            r_rburst    <= w_rburst_nxt;
            r_arready   <= w_arready_nxt;
            r_rvalid    <= w_rvalid_nxt;
            r_rid       <= w_rid_nxt;
            r_rdata     <= w_rdata_nxt;
            r_rlast     <= w_rlast_nxt;
            r_rresp     <= w_rresp_nxt;
            r_wstate    <= w_wstate_nxt;
            r_waddr     <= w_waddr_nxt;
            r_wlen      <= w_wlen_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_wburst    <= w_wburst_nxt;
            r_wid       <= w_wid_nxt;
            r_awready   <= w_awready_nxt;
            r_wready    <= w_wready_nxt;
            r_proto_err <= w_proto_nxt;
`ifdef IVS_AXI_BRESP_EN
            r_wslverr   <= w_wslverr_nxt;
            r_bvalid    <= w_bvalid_nxt;
            r_bid       <= w_bid_nxt;
            r_bresp     <= w_bresp_nxt;
`endif
        end
    end

    // Byte-enabled memory write; contents survive reset
    always_ff @(posedge i_aclk) begin
        if (w_mem_we && !i_arst) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_wstrb[i])
                    r_mem[r_waddr[ADDR_W+3:4]][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
        end
    end

    assign o_arready   = r_arready;
    assign o_rvalid    = r_rvalid;
    assign o_rid       = r_rid;
    assign o_rdata     = r_rdata;
    assign o_rlast     = r_rlast;
    assign o_rresp     = r_rresp;
    assign o_awready   = r_awready;
    assign o_wready    = r_wready;
    assign o_proto_err = r_proto_err;
`ifdef IVS_AXI_BRESP_EN
    assign o_bvalid    = r_bvalid;
    assign o_bid       = r_bid;
    assign o_bresp     = r_bresp;
`endif

endmodule

// File: tb/tb_ivs_axi_sram_slave.sv
// Self-checking bench for ivs_axi_sram_slave: randomized bursts checked against a word-array memory model.
module tb_ivs_axi_sram_slave;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORDS  = 2 ** ADDR_W;

    logic         clk = 1'b0;
    logic         i_arst;
    logic         i_arvalid, o_arready;
    logic [3:0]   i_arid;
    logic [5:0]   i_arlen;
    logic [31:0]  i_araddr;
    logic [1:0]   i_arburst;
    logic         o_rvalid, i_rready;
    logic [3:0]   o_rid;
    logic [127:0] o_rdata;
    logic         o_rlast;
    logic [1:0]   o_rresp;
    logic         i_awvalid, o_awready;
    logic [3:0]   i_awid;
    logic [5:0]   i_awlen;
    logic [31:0]  i_awaddr;
    logic [1:0]   i_awburst;
    logic         i_wvalid, o_wready;
    logic [3:0]   i_wid;
    logic [127:0] i_wdata;
    logic [15:0]  i_wstrb;
    logic         i_wlast;
`ifdef IVS_AXI_BRESP_EN
    logic         o_bvalid;
    logic [3:0]   o_bid;
    logic [1:0]   o_bresp;
    logic         i_bready;
`endif
    logic         o_proto_err;

    always #5 clk = ~clk;

    ivs_axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .i_aclk(clk), .i_arst(i_arst),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_arlen(i_arlen),
        .i_araddr(i_araddr), .i_arburst(i_arburst),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
        .o_rlast(o_rlast), .o_rresp(o_rresp),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awlen(i_awlen),
        .i_awaddr(i_awaddr), .i_awburst(i_awburst),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wid(i_wid), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_wlast(i_wlast),
`ifdef IVS_AXI_BRESP_EN
        .o_bvalid(o_bvalid), .o_bid(o_bid), .o_bresp(o_bresp), .i_bready(i_bready),
`endif
        .o_proto_err(o_proto_err)
    );

    // Reference model: plain word array plus the sticky protocol flag
    logic [127:0] model [WORDS];
    bit           exp_proto;
    logic [127:0] wq_data[$];
    logic [15:0]  wq_strb[$];
    logic [127:0] rgot[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    function automatic bit oor(input logic [31:0] a);
        return (a >> 12) != 0;
    endfunction

    task automatic fill_wq(input int n, input bit full_strb);
        wq_data.delete();
        wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back({$urandom, $urandom, $urandom, $urandom});
            wq_strb.push_back(full_strb ? 16'hFFFF : 16'($urandom));
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                               input logic [3:0] id, input int wl);
        logic [31:0] a;
        bit          slv;
        int          n;
        i_awvalid = 1'b1; i_awaddr = addr; i_awlen = 6'(len); i_awburst = burst; i_awid = id;
        n = 0;
        while (!o_awready && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 50) $display("FAIL aw_handshake: awready=%0b after %0d cycles, required 1", o_awready, n);
        else n_pass++;
        @(negedge clk);
        i_awvalid = 1'b0;
        a = addr; slv = 1'b0;
        for (int b = 0; b <= wl; b++) begin
            i_wvalid = 1'b1; i_wdata = wq_data[b]; i_wstrb = wq_strb[b]; i_wlast = (b == wl); i_wid = id;
            n = 0;
            while (!o_wready && n < 50) begin @(negedge clk); n++; end
            n_checks++;
            if (n >= 50) $display("FAIL w_handshake beat %0d: wready=%0b, required 1", b, o_wready);
            else n_pass++;
            @(negedge clk);
            if (oor(a)) slv = 1'b1;
            else for (int i = 0; i < 16; i++)
                if (wq_strb[b][i]) model[a[11:4]][i*8 +: 8] = wq_data[b][i*8 +: 8];
            if (burst != 2'b00) a = a + 32'd16;
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
        if (wl != len) exp_proto = 1'b1;
        n_checks++;
        if (o_proto_err !== exp_proto) $display("FAIL proto_err after write: got %0b, required %0b", o_proto_err, exp_proto);
        else n_pass++;
`ifdef IVS_AXI_BRESP_EN
        n = 0;
        while (!o_bvalid && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (o_bvalid !== 1'b1 || o_bid !== id || o_bresp !== (slv ? 2'b10 : 2'b00))
            $display("FAIL b_response: bvalid=%0b bid=%0h bresp=%0b, required 1 %0h %0b",
                     o_bvalid, o_bid, o_bresp, id, slv ? 2'b10 : 2'b00);
        else n_pass++;
        i_bready = 1'b1;
        @(negedge clk);
        i_bready = 1'b0;
`else
        n_checks++;
        if (o_awready !== 1'b1 || o_wready !== 1'b0)
            $display("FAIL write_end: awready=%0b wready=%0b, required 1 0", o_awready, o_wready);
        else n_pass++;
`endif
    endtask

    // mode 0: rready always high, 1: toggling 1/0, 2: random
    task automatic read_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                              input logic [3:0] id, input int mode);
        logic [31:0]  a;
        logic [127:0] prev, exp_d;
        logic [1:0]   exp_r;
        int           k, cyc, n;
        bit           tog, rdy, stalled;
        i_arvalid = 1'b1; i_araddr = addr; i_arlen = 6'(len); i_arburst = burst; i_arid = id;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 50) $display("FAIL ar_handshake: arready=%0b after %0d cycles, required 1", o_arready, n);
        else n_pass++;
        @(negedge clk);
        i_arvalid = 1'b0;
        rgot.delete();
        a = addr; k = 0; cyc = 0; tog = 1'b1; stalled = 1'b0; prev = '0;
        while (k <= len && cyc < 1000) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            if (o_rvalid) begin
                exp_d = oor(a) ? 128'h0 : model[a[11:4]];
                exp_r = oor(a) ? 2'b10 : 2'b00;
                if (stalled) begin
                    n_checks++;
                    if (o_rdata !== prev) $display("FAIL stall_hold beat %0d: rdata=%h, required %h", k, o_rdata, prev);
                    else n_pass++;
                end
                n_checks++;
                if (o_rdata !== exp_d) $display("FAIL rdata beat %0d: got %h, required %h", k, o_rdata, exp_d);
                else n_pass++;
                n_checks++;
                if (o_rresp !== exp_r) $display("FAIL rresp beat %0d: got %0b, required %0b", k, o_rresp, exp_r);
                else n_pass++;
                n_checks++;
                if (o_rlast !== (k == len)) $display("FAIL rlast beat %0d: got %0b, required %0b", k, o_rlast, k == len);
                else n_pass++;
                n_checks++;
                if (o_rid !== id) $display("FAIL rid beat %0d: got %0h, required %0h", k, o_rid, id);
                else n_pass++;
                if (rdy) begin
                    rgot.push_back(o_rdata);
                    k++;
                    if (burst != 2'b00) a = a + 32'd16;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev = o_rdata;
                end
            end
            i_rready = rdy;
            @(negedge clk);
            cyc++;
        end
        i_rready = 1'b0;
        n_checks++;
        if (k != len + 1) $display("FAIL read_beats: got %0d beats, required %0d", k, len + 1);
        else n_pass++;
        n_checks++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1)
            $display("FAIL read_end: rvalid=%0b arready=%0b, required 0 1", o_rvalid, o_arready);
        else n_pass++;
    endtask

    task automatic test_reset;
        i_arst = 1'b1;
        i_arvalid = 0; i_arid = 0; i_arlen = 0; i_araddr = 0; i_arburst = 0; i_rready = 0;
        i_awvalid = 0; i_awid = 0; i_awlen = 0; i_awaddr = 0; i_awburst = 0;
        i_wvalid = 0; i_wid = 0; i_wdata = 0; i_wstrb = 0; i_wlast = 0;
`ifdef IVS_AXI_BRESP_EN
        i_bready = 0;
`endif
        exp_proto = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_arready, o_awready, o_rvalid, o_rlast, o_wready, o_proto_err} !== 6'b110000)
            $display("FAIL reset_ctrl: ar/aw/rv/rl/wr/pe=%b, required 110000",
                     {o_arready, o_awready, o_rvalid, o_rlast, o_wready, o_proto_err});
        else n_pass++;
        n_checks++;
        if (o_rdata !== '0 || o_rid !== 4'h0 || o_rresp !== 2'b00)
            $display("FAIL reset_rdata: rdata=%h rid=%0h rresp=%0b, required 0", o_rdata, o_rid, o_rresp);
        else n_pass++;
`ifdef IVS_AXI_BRESP_EN
        n_checks++;
        if (o_bvalid !== 1'b0 || o_bid !== 4'h0 || o_bresp !== 2'b00)
            $display("FAIL reset_b: bvalid=%0b bid=%0h bresp=%0b, required 0", o_bvalid, o_bid, o_bresp);
        else n_pass++;
`endif
        i_arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill;
        for (int q = 0; q < 4; q++) begin
            fill_wq(64, 1'b1);
            write_burst(32'(q * 1024), 63, 2'b01, 4'(q), 63);
        end
    endtask

    task automatic test_incr_burst;
        fill_wq(4, 1'b1);
        write_burst(32'h0, 3, 2'b01, 4'hA, 3);
        read_burst(32'h0, 3, 2'b01, 4'hA, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rgot[i] !== wq_data[i]) $display("FAIL incr_readback %0d: got %h, required %h", i, rgot[i], wq_data[i]);
            else n_pass++;
        end
    endtask

    task automatic test_partial_strobe;
        logic [127:0] want;
        want = {{12{8'hAA}}, {4{8'h55}}};
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back({16{8'hAA}}); wq_strb.push_back(16'hFFFF);
        write_burst(32'h100, 0, 2'b01, 4'h3, 0);
        wq_data.delete(); wq_strb.delete();
        wq_data.push_back({16{8'h55}}); wq_strb.push_back(16'h000F);
        write_burst(32'h100, 0, 2'b01, 4'h3, 0);
        read_burst(32'h100, 0, 2'b01, 4'h3, 0);
        n_checks++;
        if (rgot[0] !== want) $display("FAIL partial_strobe: got %h, required %h", rgot[0], want);
        else n_pass++;
    endtask

    task automatic test_stall;
        fill_wq(8, 1'b1);
        write_burst(32'h400, 7, 2'b01, 4'h7, 7);
        read_burst(32'h400, 7, 2'b01, 4'h7, 1);
        n_checks++;
        if (rgot.size() != 8) $display("FAIL stall_count: got %0d beats, required 8", rgot.size());
        else n_pass++;
    endtask

    task automatic test_range;
        fill_wq(4, 1'b1);
        write_burst(32'hFE0, 3, 2'b01, 4'h9, 3);
        read_burst(32'hFE0, 3, 2'b01, 4'h9, 2);
        n_checks++;
        if (rgot[1] !== wq_data[1] || rgot[2] !== '0)
            $display("FAIL range_edge: beat1=%h beat2=%h, required %h and 0", rgot[1], rgot[2], wq_data[1]);
        else n_pass++;
    endtask

    task automatic test_early_wlast;
        fill_wq(4, 1'b1);
        write_burst(32'h300, 3, 2'b01, 4'h5, 1);
        read_burst(32'h300, 1, 2'b01, 4'h5, 0);
        fill_wq(4, 1'b1);
        write_burst(32'h500, 1, 2'b01, 4'h6, 3);
        read_burst(32'h500, 3, 2'b01, 4'h6, 2);
    endtask

    task automatic test_reset_mid_read;
        int n;
        i_arvalid = 1'b1; i_araddr = 32'h200; i_arlen = 6'd7; i_arburst = 2'b01; i_arid = 4'hC;
        n = 0;
        while (!o_arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        i_arvalid = 1'b0;
        i_rready = 1'b1;
        repeat (3) @(negedge clk);
        i_rready = 1'b0;
        i_arst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1 || o_rlast !== 1'b0 || o_proto_err !== 1'b0)
            $display("FAIL mid_read_reset: rvalid=%0b arready=%0b rlast=%0b proto=%0b, required 0 1 0 0",
                     o_rvalid, o_arready, o_rlast, o_proto_err);
        else n_pass++;
        i_arst = 1'b0;
        exp_proto = 1'b0;
        @(negedge clk);
        read_burst(32'h200, 3, 2'b01, 4'hD, 0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        int          len;
        logic [1:0]  bt;
        logic [3:0]  id;
        for (int t = 0; t < 25; t++) begin
            a   = {20'h0, 8'($urandom), 4'h0};
            len = $urandom_range(0, 7);
            bt  = 2'($urandom);
            id  = 4'($urandom);
            fill_wq(len + 1, 1'b0);
            write_burst(a, len, bt, id, len);
            read_burst(a, len, bt, 4'($urandom), 2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_incr_burst();
        test_partial_strobe();
        test_stall();
        test_range();
        test_early_wlast();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
